dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data and address width in bits.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of WIDTH-bit words in the backing array (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted on a cycle where req_valid=1 and req_ready=1.
REQ-007 mem_addr  input  WIDTH  byte address from the LSU.
REQ-008 mem_wdata  input  WIDTH  store data from the LSU, right-aligned.
REQ-009 mem_we  input  1  1=store, 0=load.
REQ-010 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  response consumed on a cycle where rsp_valid=1 and rsp_ready=1.
REQ-013 rsp_rdata  output  WIDTH  load result, extended to WIDTH; 0 for stores and errors.
REQ-014 rsp_err  output  1  access was misaligned, out of range or illegal funct3.

Function
REQ-015 req_ready SHALL equal (!rsp_valid || rsp_ready), so back-to-back accesses sustain one per cycle.
REQ-016 An accepted request SHALL produce exactly one response, with rsp_valid asserted on the next rising edge (latency 1).
REQ-017 rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-018 If a response is consumed and no new request is accepted in the same cycle, rsp_valid SHALL drop to 0 on the next edge.
REQ-019 Byte lane SHALL be mem_addr[1:0]; halfword lane SHALL be mem_addr[1].
REQ-020 A store SHALL write only the addressed byte lanes (SB 1 lane, SH 2 lanes, SW 4 lanes) at word index mem_addr[log2(DEPTH_WORDS)+1:2], on the acceptance edge.
REQ-021 For a store, store data SHALL be taken from the low bits of mem_wdata and shifted to the addressed lanes.
REQ-022 A load SHALL return the addressed lanes shifted to bit 0: sign-extended for B/H, zero-extended for BU/HU, unmodified for W.
REQ-023 An error SHALL be flagged if any of these holds: funct3 not in {000,001,010,100,101}; a store uses funct3 100 or 101; an H/HU access has mem_addr[0]=1; a W access has mem_addr[1:0]!=0; mem_addr >= 4*DEPTH_WORDS.
REQ-024 An erroring request SHALL NOT modify the array and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-025 A load accepted the cycle after a store to the same word SHALL return the post-store data (no hazard).
REQ-026 The array SHALL NOT be cleared by reset; its contents are undefined until written.

Reset
REQ-027 While rst=1: rsp_valid=0, rsp_err=0 and rsp_rdata=0 on the next edge, and any pending response is discarded.
REQ-028 While rst=1: req_ready=1 (it follows from REQ-015), but no store SHALL be committed and no request accepted during a reset cycle produces a response.

Structure
REQ-029 The funct3 encodings (an enum typedef for the access size) SHALL live in shared package lx32_pkg, alongside the lane-extraction helper function.
REQ-030 The byte-enable array SHALL be a sub-module, dmem_ram: one synchronous write port with 4 byte enables and one read port.
REQ-031 dmem_ctrl SHALL contain the alignment, error, extension and handshake logic.

Verification
REQ-032 SW 0xDEADBEEF to 0x10, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, one cycle after acceptance.
REQ-033 After REQ-032, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-034 SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF; the other lanes are unchanged.
REQ-035 LW 0x12, SH 0x11 and LW 4*DEPTH_WORDS -> rsp_err=1 and rsp_rdata=0; a following LW 0x10 shows the word unchanged.
REQ-036 rsp_ready held 0 for 3 cycles after a LW -> req_ready=0 and the response stays stable; the response is consumed when rsp_ready=1.
REQ-037 Back-to-back requests with rsp_ready=1 -> one response per cycle, in order.
REQ-038 rst asserted while rsp_valid=1 -> rsp_valid=0 on the next edge, and no stray response appears afterwards.

Source files
------------

// File: rtl/lx32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lx32_pkg
// Brief    : Shared load/store access-size encodings and lane-extraction helper.
// Revision : 1.0 - initial release
// ============================================================================
package lx32_pkg;

    localparam int LX_XLEN = 32;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } access_e;

    // Moves the addressed lane(s) of a word down to bit 0 and extends them.
    function automatic logic [LX_XLEN-1:0] lane_extract(
        input logic [LX_XLEN-1:0] word,
        input logic [1:0]         lane,
        input access_e            size
    );
        logic [LX_XLEN-1:0] w_shift;
        logic [7:0]         w_byte;
        logic [15:0]        w_half;
        w_shift = word >> {lane, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = lane[1] ? word[31:16] : word[15:0];
        case (size)
            F3_B:    lane_extract = {{24{w_byte[7]}}, w_byte};
            F3_H:    lane_extract = {{16{w_half[15]}}, w_half};
            F3_W:    lane_extract = word;
            F3_BU:   lane_extract = {24'd0, w_byte};
            F3_HU:   lane_extract = {16'd0, w_half};
            default: lane_extract = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ram
// Brief    : Word array with one byte-enabled synchronous write port and one
//            registered read port. Contents are never cleared.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
    input  logic [31:0]                    wdata_i,
    input  logic                           re_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Read only on enable so the output holds while a response is stalled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Data-memory controller: valid/ready handshake, alignment and
//            range checks, store lane steering and load extension (latency 1).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import lx32_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_we,
    input  logic [2:0]       funct3,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int             c_ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [WIDTH:0] c_LIMIT  = (WIDTH+1)'(4 * DEPTH_WORDS);

    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q,   rsp_err_d;
    logic                load_q,      load_d;
    access_e             size_q,      size_d;
    logic [1:0]          lane_q,      lane_d;

    logic                w_accept;
    logic                w_f3_ok;
    logic                w_misalign;
    logic                w_oor;
    logic                w_err;
    logic [3:0]          w_be;
    logic [31:0]         w_wlanes;
    logic [31:0]         w_ram_rdata;
    logic [c_ADDR_W-1:0] w_word_idx;

    assign req_ready  = !rsp_valid_q || rsp_ready;
    assign w_accept   = req_valid && req_ready;
    assign w_word_idx = mem_addr[c_ADDR_W+1:2];

    always_comb begin
        w_f3_ok    = 1'b0;
        w_misalign = 1'b0;
        case (funct3)
            F3_B:         w_f3_ok = 1'b1;
            F3_H:         begin w_f3_ok = 1'b1;    w_misalign = mem_addr[0]; end
            F3_W:         begin w_f3_ok = 1'b1;    w_misalign = (mem_addr[1:0] != 2'b00); end
            F3_BU:        w_f3_ok = !mem_we;
            F3_HU:        begin w_f3_ok = !mem_we; w_misalign = mem_addr[0]; end
            default:      w_f3_ok = 1'b0;
        endcase
    end

    assign w_oor = ({1'b0, mem_addr} >= c_LIMIT);
    assign w_err = !w_f3_ok || w_misalign || w_oor;

    // Replicating the store data across lanes lets the byte enables pick the target.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = 32'(mem_wdata);
        case (funct3)
            F3_B: begin
                w_be     = 4'b0001 << mem_addr[1:0];
                w_wlanes = {4{mem_wdata[7:0]}};
            end
            F3_H: begin
                w_be     = mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{mem_wdata[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_accept && mem_we && !w_err && !rst),
        .be_i    (w_be),
        .waddr_i (w_word_idx),
        .wdata_i (w_wlanes),
        .re_i    (w_accept && !mem_we),
        .raddr_i (w_word_idx),
        .rdata_o (w_ram_rdata)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        load_d      = load_q;
        size_d      = size_q;
        lane_d      = lane_q;
        if (w_accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = w_err;
            load_d      = !mem_we && !w_err;
            size_d      = access_e'(funct3);
            lane_d      = mem_addr[1:0];
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            load_q      <= 1'b0;
            size_q      <= F3_W;
            lane_q      <= 2'b00;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            load_q      <= load_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
        end
    end

    // Stores and errors return zero; load_q is already cleared for both.
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && load_q)
                     ? WIDTH'(lane_extract(w_ram_rdata, lane_q, size_q))
                     : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Brief    : Directed self-checking bench for dmem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;

    localparam logic [2:0] c_B  = 3'b000;
    localparam logic [2:0] c_H  = 3'b001;
    localparam logic [2:0] c_W  = 3'b010;
    localparam logic [2:0] c_BU = 3'b100;
    localparam logic [2:0] c_HU = 3'b101;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic [2:0]       funct3;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .WIDTH       (WIDTH),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .funct3    (funct3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted request; response checked one edge later, consumed on the next.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_err);
        req_valid = 1'b1;
        mem_we    = we;
        funct3    = f3;
        mem_addr  = addr;
        mem_wdata = wd;
        #1;
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rsp_err"},   32'(rsp_err),   32'(exp_err));
        check({tag, ".rsp_rdata"}, rsp_rdata,      exp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        mem_we    = 1'b0;
        funct3    = c_W;
        mem_addr  = '0;
        mem_wdata = '0;

        step(); step(); step();
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.rsp_err",   32'(rsp_err),   32'd0);
        check("reset.rsp_rdata", rsp_rdata,      32'd0);
        check("reset.req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        // Word store then byte/half loads of every flavour.
        xact("sw10",   1'b1, c_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        xact("lw10",   1'b0, c_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        xact("lb13",   1'b0, c_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
        xact("lbu13",  1'b0, c_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0);
        xact("lh12",   1'b0, c_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
        xact("lhu10",  1'b0, c_HU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);
        xact("lb10",   1'b0, c_B,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);

        // Byte store into lane 1; upper wdata bits must be ignored.
        xact("sb11",   1'b1, c_B,  32'h11, 32'hFFFFFF55, 32'h0,        1'b0);
        xact("lw10b",  1'b0, c_W,  32'h10, 32'h0,        32'hDEAD55EF, 1'b0);

        // Halfword store into the upper lane pair.
        xact("sw14",   1'b1, c_W,  32'h14, 32'h00000000, 32'h0,        1'b0);
        xact("sh16",   1'b1, c_H,  32'h16, 32'hABCD1234, 32'h0,        1'b0);
        xact("lw14",   1'b0, c_W,  32'h14, 32'h0,        32'h12340000, 1'b0);
        xact("lhu16",  1'b0, c_HU, 32'h16, 32'h0,        32'h00001234, 1'b0);

        // Error cases, none of which may touch the array.
        xact("lw12e",  1'b0, c_W,  32'h12, 32'h0,        32'h0,        1'b1);
        xact("sh11e",  1'b1, c_H,  32'h11, 32'h0000FFFF, 32'h0,        1'b1);
        xact("lwoor",  1'b0, c_W,  32'(4*DEPTH), 32'h0,  32'h0,        1'b1);
        xact("swoor",  1'b1, c_W,  32'(4*DEPTH), 32'h0,  32'h0,        1'b1);
        xact("lf3bad", 1'b0, 3'b011, 32'h10, 32'h0,      32'h0,        1'b1);
        xact("sbue",   1'b1, c_BU, 32'h10, 32'h00000077, 32'h0,        1'b1);
        xact("shue",   1'b1, c_HU, 32'h10, 32'h00007777, 32'h0,        1'b1);
        xact("lw10c",  1'b0, c_W,  32'h10, 32'h0,        32'hDEAD55EF, 1'b0);

        // Backpressure: a second load waits behind the stalled response.
        req_valid = 1'b1; mem_we = 1'b0; funct3 = c_W; mem_addr = 32'h10;
        step();
        mem_addr  = 32'h14;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.req_ready", 32'(req_ready), 32'd0);
            check("stall.rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall.rsp_rdata", rsp_rdata,      32'hDEAD55EF);
            check("stall.rsp_err",   32'(rsp_err),   32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("unstall.req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("after.rsp_valid", 32'(rsp_valid), 32'd1);
        check("after.rsp_rdata", rsp_rdata,      32'h12340000);
        step();
        check("drain.rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset while a response is pending, and a store during reset.
        req_valid = 1'b1; mem_we = 1'b0; funct3 = c_W; mem_addr = 32'h10;
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("pre_rst.rsp_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        step();
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_err",   32'(rsp_err),   32'd0);
        check("rst.rsp_rdata", rsp_rdata,      32'd0);
        rsp_ready = 1'b1;
        req_valid = 1'b1; mem_we = 1'b1; funct3 = c_W; mem_addr = 32'h10; mem_wdata = 32'h11111111;
        step();
        check("rst_sw.rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        req_valid = 1'b0;
        step();
        check("post_rst1.rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        check("post_rst2.rsp_valid", 32'(rsp_valid), 32'd0);
        xact("lw10d", 1'b0, c_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
        step();
        check("end.rsp_valid", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
